// File: rtl/core_mem_rd_arbiter.sv
// Two-master AXI-lite read arbiter (M0 = fetch, M1 = load) onto one memory read port.
// One transaction in flight; the grant is held from arbitration through the R handshake.

module core_mem_rd_arbiter_port #(
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  gnt,
  input  logic                  in_addr,
  input  logic                  in_data,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [AXI_DWIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  arready,
  output logic                  rvalid,
  output logic [AXI_DWIDTH-1:0] rdata,
  output logic [1:0]            rresp
);
  assign arready = in_addr & gnt & s_arready;
  assign rvalid  = in_data & gnt & s_rvalid;
  assign rdata   = s_rdata;
  assign rresp   = s_rresp;
endmodule

module core_mem_rd_arbiter #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32,
  parameter int ARB_RR     = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic [AXI_AWIDTH-1:0] M0_ARADDR,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [AXI_DWIDTH-1:0] M0_RDATA,
  output logic [1:0]            M0_RRESP,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,
  input  logic [AXI_AWIDTH-1:0] M1_ARADDR,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [AXI_DWIDTH-1:0] M1_RDATA,
  output logic [1:0]            M1_RRESP,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,
  output logic [AXI_AWIDTH-1:0] S_ARADDR,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [AXI_DWIDTH-1:0] S_RDATA,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  output logic [1:0]            GNT
);
  localparam int NM = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] gnt_q;
  logic [3:0] wait_q;
  logic       last_q;   // 1: M1 was granted last
  logic       win_m1;
  logic       win_arvalid;
  logic       win_rready;
  logic       in_addr;
  logic       in_data;

  logic [NM-1:0]                 arvalid;
  logic [NM-1:0]                 rready;
  logic [NM-1:0]                 arready;
  logic [NM-1:0]                 rvalid;
  logic [NM-1:0][AXI_DWIDTH-1:0] rdata;
  logic [NM-1:0][1:0]            rresp;

  assign arvalid = {M1_ARVALID, M0_ARVALID};
  assign rready  = {M1_RREADY, M0_RREADY};

  assign win_arvalid = |(gnt_q & arvalid);
  assign win_rready  = |(gnt_q & rready);

  // Winner selection; only consumed in IDLE when at least one master requests.
  always_comb begin
    win_m1 = 1'b0;
    if (ARB_RR != 0) begin
      if (M0_ARVALID && M1_ARVALID) win_m1 = ~last_q;
      else                          win_m1 = M1_ARVALID;
    end else begin
      if (M0_ARVALID && (wait_q == 4'(MAX_WAIT))) win_m1 = 1'b0;
      else                                         win_m1 = M1_ARVALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (|arvalid) state_nx = ST_ADDR;
      ST_ADDR: begin
        if (!win_arvalid)   state_nx = ST_IDLE;
        else if (S_ARREADY) state_nx = ST_DATA;
      end
      ST_DATA: if (S_RVALID && win_rready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Qualifiers are forced low while NRST is asserted so the reset cycle is quiet.
  always_comb begin
    in_addr = 1'b0;
    in_data = 1'b0;
    if (NRST) begin
      case (state)
        ST_ADDR: in_addr = 1'b1;
        ST_DATA: in_data = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      gnt_q  <= 2'b00;
      wait_q <= 4'd0;
      last_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|arvalid) begin
            gnt_q  <= win_m1 ? 2'b10 : 2'b01;
            last_q <= win_m1;
            if (!win_m1)                    wait_q <= 4'd0;
            else if (M0_ARVALID && wait_q != 4'hf) wait_q <= wait_q + 4'd1;
          end
        end
        ST_ADDR: if (!win_arvalid) gnt_q <= 2'b00;
        ST_DATA: if (S_RVALID && win_rready) gnt_q <= 2'b00;
        default: gnt_q <= 2'b00;
      endcase
    end
  end

  assign GNT       = gnt_q;
  assign S_ARADDR  = gnt_q[1] ? M1_ARADDR : M0_ARADDR;
  assign S_ARVALID = in_addr & win_arvalid;
  assign S_RREADY  = in_data & win_rready;

  for (genvar g = 0; g < NM; g++) begin : g_port
    core_mem_rd_arbiter_port #(.AXI_DWIDTH(AXI_DWIDTH)) u_port (
      .gnt       (gnt_q[g]),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .s_arready (S_ARREADY),
      .s_rvalid  (S_RVALID),
      .s_rdata   (S_RDATA),
      .s_rresp   (S_RRESP),
      .arready   (arready[g]),
      .rvalid    (rvalid[g]),
      .rdata     (rdata[g]),
      .rresp     (rresp[g])
    );
  end

  assign M0_ARREADY = arready[0];
  assign M0_RVALID  = rvalid[0];
  assign M0_RDATA   = rdata[0];
  assign M0_RRESP   = rresp[0];
  assign M1_ARREADY = arready[1];
  assign M1_RVALID  = rvalid[1];
  assign M1_RDATA   = rdata[1];
  assign M1_RRESP   = rresp[1];

endmodule

// File: tb/tb_core_mem_rd_arbiter.sv
// Random two-master traffic against a fixed-priority (MAX_WAIT=2) and a round-robin instance,
// checked cycle by cycle against a transaction-level model of the arbitration rules.

module tb_core_mem_rd_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MW = 2;
  localparam int P_FREE = 0, P_ADDR = 1, P_DATA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  // [k][m]: k = instance (0 fixed, 1 rr), m = master
  logic [AW-1:0] araddr  [2][2];
  logic          arvalid [2][2];
  logic          arready [2][2];
  logic [DW-1:0] rdata   [2][2];
  logic [1:0]    rresp   [2][2];
  logic          rvalid  [2][2];
  logic          rready  [2][2];
  logic [AW-1:0] s_araddr  [2];
  logic          s_arvalid [2];
  logic          s_arready [2];
  logic [DW-1:0] s_rdata   [2];
  logic [1:0]    s_rresp   [2];
  logic          s_rvalid  [2];
  logic          s_rready  [2];
  logic [1:0]    gnt       [2];

  core_mem_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ARB_RR(0), .MAX_WAIT(MW)) u_fix (
    .CLK(clk), .NRST(nrst),
    .M0_ARADDR(araddr[0][0]), .M0_ARVALID(arvalid[0][0]), .M0_ARREADY(arready[0][0]),
    .M0_RDATA(rdata[0][0]), .M0_RRESP(rresp[0][0]), .M0_RVALID(rvalid[0][0]), .M0_RREADY(rready[0][0]),
    .M1_ARADDR(araddr[0][1]), .M1_ARVALID(arvalid[0][1]), .M1_ARREADY(arready[0][1]),
    .M1_RDATA(rdata[0][1]), .M1_RRESP(rresp[0][1]), .M1_RVALID(rvalid[0][1]), .M1_RREADY(rready[0][1]),
    .S_ARADDR(s_araddr[0]), .S_ARVALID(s_arvalid[0]), .S_ARREADY(s_arready[0]),
    .S_RDATA(s_rdata[0]), .S_RRESP(s_rresp[0]), .S_RVALID(s_rvalid[0]), .S_RREADY(s_rready[0]),
    .GNT(gnt[0])
  );

  core_mem_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ARB_RR(1), .MAX_WAIT(MW)) u_rr (
    .CLK(clk), .NRST(nrst),
    .M0_ARADDR(araddr[1][0]), .M0_ARVALID(arvalid[1][0]), .M0_ARREADY(arready[1][0]),
    .M0_RDATA(rdata[1][0]), .M0_RRESP(rresp[1][0]), .M0_RVALID(rvalid[1][0]), .M0_RREADY(rready[1][0]),
    .M1_ARADDR(araddr[1][1]), .M1_ARVALID(arvalid[1][1]), .M1_ARREADY(arready[1][1]),
    .M1_RDATA(rdata[1][1]), .M1_RRESP(rresp[1][1]), .M1_RVALID(rvalid[1][1]), .M1_RREADY(rready[1][1]),
    .S_ARADDR(s_araddr[1]), .S_ARVALID(s_arvalid[1]), .S_ARREADY(s_arready[1]),
    .S_RDATA(s_rdata[1]), .S_RRESP(s_rresp[1]), .S_RVALID(s_rvalid[1]), .S_RREADY(s_rready[1]),
    .GNT(gnt[1])
  );

  int unsigned errs = 0, chks = 0;
  int          ph [2], own [2], mwait [2], mlast [2], sdly [2];
  int          done [2][2];
  bit          req [2][2], wr [2][2], sp [2];
  logic [AW-1:0] maddr [2][2];
  logic [AW-1:0] saddr [2];
  logic [1:0]    sresp [2];
  int  forced = 0, flushes = 0;
  bit  stray = 0, rst_req = 1, rst_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return 32'h00500093 ^ {8{a}};
  endfunction

  task automatic drive(input int k);
    for (int m = 0; m < 2; m++) begin
      if (nrst && !stray) begin
        if (!req[k][m] && !wr[k][m]) begin
          if ($urandom_range(0, 3) < ((m == 1) ? 3 : 2)) begin
            req[k][m]   = 1'b1;
            maddr[k][m] = AW'($urandom);
          end
        end else if (req[k][m] && $urandom_range(0, 15) == 0) begin
          req[k][m] = 1'b0;
        end
      end
      arvalid[k][m] = req[k][m] && !stray;
      araddr[k][m]  = req[k][m] ? maddr[k][m] : AW'($urandom);
      rready[k][m]  = ($urandom_range(0, 3) != 0);
    end
    s_arready[k] = 1'($urandom_range(0, 1));
    if (stray) begin
      s_rvalid[k] = 1'b1; s_rdata[k] = $urandom; s_rresp[k] = 2'b10;
    end else if (sp[k] && sdly[k] == 0) begin
      s_rvalid[k] = 1'b1; s_rdata[k] = fdat(saddr[k]); s_rresp[k] = sresp[k];
    end else begin
      s_rvalid[k] = 1'b0; s_rdata[k] = $urandom; s_rresp[k] = 2'($urandom);
    end
  endtask

  task automatic check(input int k);
    logic [7:0] obs, exp;
    logic [1:0] g;
    int o;
    o   = own[k];
    obs = {gnt[k], s_arvalid[k], arready[k][1], arready[k][0], rvalid[k][1], rvalid[k][0], s_rready[k]};
    if (!nrst) begin
      chk("rst_ctl", 64'(obs[5:0]), 64'd0);
    end else begin
      g = (o == 1) ? 2'b10 : 2'b01;
      case (ph[k])
        P_ADDR:  exp = {g, arvalid[k][o], 1'(o == 1 && s_arready[k]), 1'(o == 0 && s_arready[k]), 3'b000};
        P_DATA:  exp = {g, 3'b000, 1'(o == 1 && s_rvalid[k]), 1'(o == 0 && s_rvalid[k]), rready[k][o]};
        default: exp = 8'h00;
      endcase
      chk((k == 0) ? "ctl_fix" : "ctl_rr", 64'(obs), 64'(exp));
      if (ph[k] == P_ADDR && arvalid[k][o])
        chk("araddr", 64'(s_araddr[k]), 64'(maddr[k][o]));
      if (ph[k] == P_DATA && s_rvalid[k] && rready[k][o])
        chk("rdata", 64'({rresp[k][o], rdata[k][o]}), 64'({sresp[k], fdat(maddr[k][o])}));
    end
  endtask

  task automatic advance(input int k);
    int o, w;
    bit a0, a1;
    o = own[k];
    if (sp[k] && sdly[k] > 0) sdly[k]--;
    if (!nrst) begin
      ph[k] = P_FREE; mwait[k] = 0; mlast[k] = 1; sp[k] = 0;
      for (int m = 0; m < 2; m++) begin req[k][m] = 0; wr[k][m] = 0; end
      return;
    end
    case (ph[k])
      P_FREE: begin
        a0 = arvalid[k][0]; a1 = arvalid[k][1];
        if (a0 || a1) begin
          if (k == 1) begin
            w = (a0 && a1) ? 1 - mlast[k] : int'(a1);
          end else begin
            w = (a0 && mwait[k] == MW) ? 0 : int'(a1);
            if (a0 && a1 && mwait[k] == MW) forced++;
          end
          if (w == 1 && a0) mwait[k] = (mwait[k] < 15) ? mwait[k] + 1 : 15;
          else if (w == 0)  mwait[k] = 0;
          mlast[k] = w; own[k] = w; ph[k] = P_ADDR;
        end
      end
      P_ADDR: begin
        if (!arvalid[k][o]) begin
          ph[k] = P_FREE; flushes++;
        end else if (s_arready[k]) begin
          ph[k] = P_DATA; req[k][o] = 0; wr[k][o] = 1;
          sp[k] = 1; saddr[k] = s_araddr[k]; sdly[k] = $urandom_range(0, 2);
          sresp[k] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
      end
      default: begin
        if (s_rvalid[k] && rready[k][o]) begin
          ph[k] = P_FREE; wr[k][o] = 0; sp[k] = 0; done[k][o]++;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    nrst = !rst_req;
    for (int k = 0; k < 2; k++) drive(k);
    #1;
    for (int k = 0; k < 2; k++) begin check(k); advance(k); end
    stray = 0;
  endtask

  initial begin
    nrst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_FREE; own[k] = 0; mwait[k] = 0; mlast[k] = 1; sdly[k] = 0; sp[k] = 0;
      saddr[k] = '0; sresp[k] = '0;
      s_arready[k] = 0; s_rvalid[k] = 0; s_rdata[k] = '0; s_rresp[k] = '0;
      for (int m = 0; m < 2; m++) begin
        req[k][m] = 0; wr[k][m] = 0; done[k][m] = 0; maddr[k][m] = '0;
        arvalid[k][m] = 0; araddr[k][m] = '0; rready[k][m] = 0;
      end
    end
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    for (int i = 0; i < 3000; i++) begin
      // Reset the fabric mid-transaction, then present a stale S_RVALID.
      if (!rst_done && i > 1000 && ph[0] == P_DATA) begin
        rst_req = 1; step(); rst_req = 0;
        stray = 1; rst_done = 1;
      end
      step();
    end
    chk("rst_hit", 64'(rst_done), 64'd1);
    chk("forced_m0", 64'(forced > 0), 64'd1);
    chk("flushes", 64'(flushes > 0), 64'd1);
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++)
        chk("served", 64'(done[k][m] > 0), 64'd1);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
